// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader
// Pops fixed-length frames out of an upstream prefetch FIFO and presents them
// as a valid/ready stream with first-beat (m_sop) and last-beat (m_eop) flags.
// A 2-entry skid buffer decouples the FIFO pop from downstream back-pressure,
// giving 1-cycle pop-to-beat latency and full throughput when nothing stalls.
module fifo_frame_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  start,
    input  logic                  cont,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic                  abort,
    input  logic                  fifo_rd_vld,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_cnt
);

    // Counters carry one extra bit so a frame_len of 0 can mean 2^LEN_WIDTH.
    localparam int CNT_WIDTH = LEN_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [CNT_WIDTH-1:0]   len_q;
    logic [CNT_WIDTH-1:0]   len_in;
    logic [CNT_WIDTH-1:0]   last_idx;
    logic [CNT_WIDTH-1:0]   pop_cnt_q;
    logic [CNT_WIDTH-1:0]   out_cnt_q;

    logic [DATA_WIDTH-1:0]  skid_q [2];
    logic [1:0]             occ_q;
    logic [1:0]             occ_after_out;

    logic [15:0]            frame_cnt_q;

    logic                   go;
    logic                   load;
    logic                   in_frame_abort;
    logic                   accept;
    logic                   push;
    logic                   last_pop;
    logic                   last_beat;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign len_in         = (frame_len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}}
                                              : {1'b0, frame_len};
    assign last_idx       = len_q - CNT_WIDTH'(1);

    // abort outranks start and cont wherever both could act.
    assign go             = (start | cont) & ~abort;
    assign load           = ((state_q == IDLE) & go)
                          | ((state_q == DONE) & cont & ~abort);
    assign in_frame_abort = abort & ((state_q == RUN) | (state_q == DRAIN));

    assign m_valid        = (occ_q != 2'd0);
    assign accept         = m_valid & m_ready;

    // Occupancy once this cycle's output handshake has retired; a pop is
    // allowed only if the pushed word will still find a free slot.
    assign occ_after_out  = occ_q - {1'b0, accept};

    assign push           = (state_q == RUN) & ~abort & fifo_rd_vld
                          & (pop_cnt_q < len_q) & (occ_after_out < 2'd2);
    assign fifo_rd_en     = push;

    assign last_pop       = push & (pop_cnt_q == last_idx);
    assign last_beat      = accept & (out_cnt_q == last_idx);

    // Stream outputs come straight from the head of the skid buffer and the
    // output beat counter, so they cannot change while a beat is stalled.
    assign m_data         = skid_q[0];
    assign m_sop          = m_valid & (out_cnt_q == '0);
    assign m_eop          = m_valid & (out_cnt_q == last_idx);

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign frame_cnt      = frame_cnt_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    // NOTE: state_d is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_pop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = (cont & ~abort) ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame length latch and pop / beat counters
    // ------------------------------------------------------------------

    // Latch L and clear both counters at every frame start; count pops and
    // accepted beats in between.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            len_q     <= '0;
            pop_cnt_q <= '0;
            out_cnt_q <= '0;
        end else if (load) begin
            len_q     <= len_in;
            pop_cnt_q <= '0;
            out_cnt_q <= '0;
        end else begin
            if (push) begin
                pop_cnt_q <= pop_cnt_q + CNT_WIDTH'(1);
            end
            if (accept) begin
                out_cnt_q <= out_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry skid buffer (skid_q[0] is the head)
    // ------------------------------------------------------------------

    // Push popped FIFO words at the tail, retire accepted beats from the head,
    // and empty the buffer when a frame is aborted.
    // NOTE: the two storage words are reset as well; they are only two
    // registers and m_data must read 0 while reset is asserted.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            occ_q     <= 2'd0;
        end else if (in_frame_abort) begin
            occ_q     <= 2'd0;
        end else begin
            unique case ({accept, push})
                2'b01: begin
                    if (occ_q == 2'd0) begin
                        skid_q[0] <= fifo_rd_data;
                    end else begin
                        skid_q[1] <= fifo_rd_data;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b10: begin
                    skid_q[0] <= skid_q[1];
                    occ_q     <= occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; shift and refill the tail.
                    if (occ_q == 2'd2) begin
                        skid_q[0] <= skid_q[1];
                        skid_q[1] <= fifo_rd_data;
                    end else begin
                        skid_q[0] <= fifo_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Completed-frame counter
    // ------------------------------------------------------------------

    // Count one frame per DONE cycle; wraps naturally at 16 bits.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            frame_cnt_q <= 16'd0;
        end else if (state_q == DONE) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

endmodule
